// File: rtl/ifu_pkg.sv
// Shared types and helpers for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        TRAP = 2'd0,
        BR   = 2'd1,
        JMP  = 2'd2,
        NONE = 2'd3
    } redir_src_t;

    // RVC encodings are every opcode whose two low bits are not 2'b11.
    function automatic logic is_compressed(input logic [31:0] instr);
        return instr[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/redirect_sel.sv
// Fixed-priority selection of the redirect sources: trap > branch > jump.
module redirect_sel
    import ifu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_addr,
    output logic            redir,
    output logic [XLEN-1:0] target,
    output redir_src_t      src
);

    // Priority mux over the three redirect requests.
    always_comb begin
        redir  = 1'b0;
        target = '0;
        src    = NONE;
        if (trap_en) begin
            redir  = 1'b1;
            target = trap_addr;
            src    = TRAP;
        end else if (br_en) begin
            redir  = 1'b1;
            target = br_addr;
            src    = BR;
        end else if (jmp_en) begin
            redir  = 1'b1;
            target = jmp_addr;
            src    = JMP;
        end else begin
            redir  = 1'b0;
            target = '0;
            src    = NONE;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IFU sequencer: drives the PC block, runs the imem req/ack handshake and
// holds one fetched instruction for decode, dropping fetches made stale by a redirect.
module fetch_ctrl
    import ifu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int C_EXT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] curr_pc,
    output logic            pc_stall,
    output logic            pc_je,
    output logic [XLEN-1:0] pc_ja,
    output logic            pc_compressed,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_addr,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_addr,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic            if_compressed
);

    fetch_state_t    state_r, next_s;
    logic            redir_s;
    logic [XLEN-1:0] target_s;
    redir_src_t      src_s;

    logic            pending_r;
    logic [XLEN-1:0] pend_addr_r;
    logic            if_valid_r;
    logic [31:0]     if_instr_r;
    logic [XLEN-1:0] if_pc_r;
    logic            if_comp_r;

    logic            stall_s, je_s, comp_s, req_s;
    logic [XLEN-1:0] ja_s;
    logic            capture_s, set_pend_s, clr_pend_s;
    logic            rdata_comp_s;

    redirect_sel #(.XLEN(XLEN)) u_redirect_sel (
        .trap_en   (trap_en),
        .trap_addr (trap_addr),
        .br_en     (br_en),
        .br_addr   (br_addr),
        .jmp_en    (jmp_en),
        .jmp_addr  (jmp_addr),
        .redir     (redir_s),
        .target    (target_s),
        .src       (src_s)
    );

    assign rdata_comp_s = (C_EXT != 0) && is_compressed(imem_rdata);

    // Next-state and PC/memory control; reset forces the idle output values.
    always_comb begin
        next_s     = state_r;
        stall_s    = 1'b1;
        je_s       = 1'b0;
        ja_s       = '0;
        comp_s     = 1'b0;
        req_s      = 1'b0;
        capture_s  = 1'b0;
        set_pend_s = 1'b0;
        clr_pend_s = 1'b0;
        case (state_r)
            IDLE: begin
                next_s = FETCH;
                if (redir_s) begin
                    stall_s = 1'b0;
                    je_s    = 1'b1;
                    ja_s    = target_s;
                end else begin
                    stall_s = 1'b1;
                end
            end
            FETCH: begin
                req_s = 1'b1;
                if (imem_ack && !redir_s) begin
                    capture_s = 1'b1;
                    stall_s   = 1'b0;
                    comp_s    = rdata_comp_s;
                    next_s    = HOLD;
                end else if (imem_ack && redir_s) begin
                    stall_s = 1'b0;
                    je_s    = 1'b1;
                    ja_s    = target_s;
                    next_s  = FETCH;
                end else if (redir_s) begin
                    set_pend_s = 1'b1;
                    next_s     = FLUSH;
                end else begin
                    next_s = FETCH;
                end
            end
            HOLD: begin
                if (redir_s) begin
                    stall_s = 1'b0;
                    je_s    = 1'b1;
                    ja_s    = target_s;
                    next_s  = FETCH;
                end else if (if_ready && if_valid_r) begin
                    next_s = FETCH;
                end else begin
                    next_s = HOLD;
                end
            end
            FLUSH: begin
                // The outstanding request stays on the bus until memory answers.
                req_s = 1'b1;
                if (imem_ack) begin
                    clr_pend_s = 1'b1;
                    next_s     = FETCH;
                    if (src_s != NONE) begin
                        stall_s = 1'b0;
                        je_s    = 1'b1;
                        ja_s    = target_s;
                    end else if (pending_r) begin
                        stall_s = 1'b0;
                        je_s    = 1'b1;
                        ja_s    = pend_addr_r;
                    end else begin
                        stall_s = 1'b1;
                    end
                end else if (redir_s) begin
                    set_pend_s = 1'b1;
                end else begin
                    next_s = FLUSH;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
        if (reset) begin
            stall_s    = 1'b1;
            je_s       = 1'b0;
            ja_s       = '0;
            comp_s     = 1'b0;
            req_s      = 1'b0;
            capture_s  = 1'b0;
            set_pend_s = 1'b0;
            clr_pend_s = 1'b0;
        end else begin
            next_s = next_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Pending redirect target captured while a stale fetch is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_r   <= 1'b0;
            pend_addr_r <= '0;
        end else if (clr_pend_s) begin
            pending_r   <= 1'b0;
        end else if (set_pend_s) begin
            pending_r   <= 1'b1;
            pend_addr_r <= target_s;
        end else begin
            pending_r   <= pending_r;
        end
    end

    // Decode buffer: any redirect flushes it, decode consumption frees it.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_r <= 1'b0;
            if_instr_r <= 32'h0000_0000;
            if_pc_r    <= '0;
            if_comp_r  <= 1'b0;
        end else if (redir_s) begin
            if_valid_r <= 1'b0;
        end else if (capture_s) begin
            if_valid_r <= 1'b1;
            if_instr_r <= imem_rdata;
            if_pc_r    <= curr_pc;
            if_comp_r  <= rdata_comp_s;
        end else if (if_ready) begin
            if_valid_r <= 1'b0;
        end else begin
            if_valid_r <= if_valid_r;
        end
    end

    assign pc_stall      = stall_s;
    assign pc_je         = je_s;
    assign pc_ja         = ja_s;
    assign pc_compressed = comp_s;
    assign imem_req      = req_s;
    assign imem_addr     = curr_pc;
    assign if_valid      = if_valid_r;
    assign if_instr      = if_instr_r;
    assign if_pc         = if_pc_r;
    assign if_compressed = if_comp_r;

endmodule
